// File: rtl/flag_pkg.sv
// Shared types and helpers for the status-flag sequencer: condition codes,
// flag write classes and their masks, and the branch condition evaluator.
package flag_pkg;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_S = 2;
  localparam int FLAG_O = 3;

  typedef enum logic [3:0] {
    EQ, NE, CS, CC, MI, PL, VS, VC, GT, LE, GE, LT, HI, LS, AL, NV
  } cond_e;

  typedef enum logic [1:0] {NONE, ZS, ZCS, ALL} flag_class_e;

  localparam logic [3:0] MASK_NONE = 4'b0000;
  localparam logic [3:0] MASK_ZS   = 4'b0101;
  localparam logic [3:0] MASK_ZCS  = 4'b0111;
  localparam logic [3:0] MASK_ALL  = 4'b1111;

  function automatic flag_class_e op_class(input logic [4:0] op);
    flag_class_e c;
    c = NONE;
    case (op) inside
      5'b00000, 5'b00001, 5'b00011, 5'b00100, 5'b00101, 5'b00110: c = ALL;
      5'b01000, 5'b01001:                                         c = ZCS;
      5'b10001, 5'b10010, [5'b10100:5'b11110]:                    c = ZS;
      default:                                                    c = NONE;
    endcase
    return c;
  endfunction

  function automatic logic [3:0] class_mask(input flag_class_e c);
    logic [3:0] m;
    case (c)
      ALL:     m = MASK_ALL;
      ZCS:     m = MASK_ZCS;
      ZS:      m = MASK_ZS;
      default: m = MASK_NONE;
    endcase
    return m;
  endfunction

  function automatic logic cond_eval(input cond_e cc, input logic [3:0] f);
    logic z, c, s, o, r;
    z = f[FLAG_Z];
    c = f[FLAG_C];
    s = f[FLAG_S];
    o = f[FLAG_O];
    case (cc)
      EQ:      r = z;
      NE:      r = !z;
      CS:      r = c;
      CC:      r = !c;
      MI:      r = s;
      PL:      r = !s;
      VS:      r = o;
      VC:      r = !o;
      GT:      r = !z && (s == o);
      LE:      r = z || (s != o);
      GE:      r = (s == o);
      LT:      r = (s != o);
      HI:      r = c && !z;
      LS:      r = !c || z;
      AL:      r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/flag_stack.sv
// DEPTH x 4-bit LIFO for flag save/restore. Read port is registered and always
// tracks the top entry, so a pop accepted one cycle earlier finds its data ready.
module flag_stack #(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [3:0] wr_data,
  output logic [3:0] rd_data,
  output logic       full,
  output logic       empty
);

  localparam int AW  = $clog2(DEPTH);
  localparam int SPW = AW + 1;

  logic [3:0]     mem [DEPTH];
  logic [SPW-1:0] sp_reg;
  logic [3:0]     rd_data_reg;
  logic [AW-1:0]  wr_addr;
  logic [AW-1:0]  rd_addr;

  assign full    = (sp_reg == SPW'(DEPTH));
  assign empty   = (sp_reg == '0);
  assign wr_addr = sp_reg[AW-1:0];
  assign rd_addr = AW'(sp_reg - SPW'(1));
  assign rd_data = rd_data_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      sp_reg <= '0;
    end else if (push && !full) begin
      sp_reg <= sp_reg + SPW'(1);
    end else if (pop && !empty) begin
      sp_reg <= sp_reg - SPW'(1);
    end
  end

  // Storage carries no reset so it maps onto plain RAM.
  always_ff @(posedge clock) begin
    if (push && !full) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_reg <= mem[rd_addr];
  end

endmodule

// File: rtl/flag_sequencer.sv
// Status flag controller: masked ALU flag writes, save/restore LIFO, branch
// condition queries. Optional build macro FLAG_FWD_EN forwards same-cycle updates to queries.
module flag_sequencer
  import flag_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       alu_valid,
  output logic       alu_ready,
  input  logic [4:0] alu_op,
  input  logic [3:0] alu_flags,
  input  logic       save_req,
  input  logic       restore_req,
  output logic       stk_ready,
  input  logic       cond_valid,
  input  logic [3:0] cond_code,
  output logic       cond_ready,
  output logic       cond_done,
  output logic       cond_taken,
  output logic [3:0] flags,
  output logic       stack_err
);

  typedef enum logic [1:0] {IDLE, PUSH, POP} state_e;

  state_e     state_reg;
  logic [3:0] flags_reg;
  logic       stack_err_reg;
  logic       cond_done_reg;
  logic       cond_taken_reg;

  logic       alu_fire;
  logic       cond_fire;
  logic [3:0] alu_mask;
  logic [3:0] flags_next;
  logic [3:0] eval_flags;
  logic [3:0] stk_rd_data;
  logic       stk_full;
  logic       stk_empty;

  assign alu_ready  = (state_reg == IDLE) && !save_req && !restore_req;
  assign stk_ready  = (state_reg == IDLE) && (save_req || restore_req);
  assign alu_fire   = alu_valid && alu_ready;
  assign alu_mask   = class_mask(op_class(alu_op));
  assign flags_next = (flags_reg & ~alu_mask) | (alu_flags & alu_mask);

`ifdef FLAG_FWD_EN
  assign cond_ready = (state_reg != POP);
  assign eval_flags = alu_fire ? flags_next : flags_reg;
`else
  // Hold off queries while an update lands so they see the settled register.
  assign cond_ready = (state_reg != POP) && !alu_fire;
  assign eval_flags = flags_reg;
`endif

  assign cond_fire = cond_valid && cond_ready;

  flag_stack #(.DEPTH(DEPTH)) u_stack (
    .clock   (clock),
    .reset   (reset),
    .push    (state_reg == PUSH),
    .pop     (state_reg == POP),
    .wr_data (flags_reg),
    .rd_data (stk_rd_data),
    .full    (stk_full),
    .empty   (stk_empty)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      flags_reg      <= '0;
      stack_err_reg  <= 1'b0;
      cond_done_reg  <= 1'b0;
      cond_taken_reg <= 1'b0;
    end else begin
      cond_done_reg <= cond_fire;
      if (cond_fire) begin
        cond_taken_reg <= cond_eval(cond_e'(cond_code), eval_flags);
      end
      case (state_reg)
        IDLE: begin
          if (alu_fire) begin
            flags_reg <= flags_next;
          end
          if (restore_req) begin
            state_reg <= POP;
          end else if (save_req) begin
            state_reg <= PUSH;
          end
        end
        PUSH: begin
          if (stk_full) begin
            stack_err_reg <= 1'b1;
          end
          state_reg <= IDLE;
        end
        POP: begin
          if (stk_empty) begin
            stack_err_reg <= 1'b1;
          end else begin
            flags_reg <= stk_rd_data;
          end
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign flags      = flags_reg;
  assign stack_err  = stack_err_reg;
  assign cond_done  = cond_done_reg;
  assign cond_taken = cond_taken_reg;

endmodule

// File: tb/tb_flag_sequencer.sv
// Directed bench for flag_sequencer with a scoreboard queue for condition results.
module tb_flag_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       alu_valid = 1'b0;
  logic       alu_ready;
  logic [4:0] alu_op = '0;
  logic [3:0] alu_flags = '0;
  logic       save_req = 1'b0;
  logic       restore_req = 1'b0;
  logic       stk_ready;
  logic       cond_valid = 1'b0;
  logic [3:0] cond_code = '0;
  logic       cond_ready;
  logic       cond_done;
  logic       cond_taken;
  logic [3:0] flags;
  logic       stack_err;

  int compared = 0;
  int mismatched = 0;

  logic [3:0] exp_flags;
  logic       exp_err;
  logic [3:0] mstack[$];
  logic       exp_q[$];

  always #5 clock = ~clock;

  flag_sequencer #(.DEPTH(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_op      (alu_op),
    .alu_flags   (alu_flags),
    .save_req    (save_req),
    .restore_req (restore_req),
    .stk_ready   (stk_ready),
    .cond_valid  (cond_valid),
    .cond_code   (cond_code),
    .cond_ready  (cond_ready),
    .cond_done   (cond_done),
    .cond_taken  (cond_taken),
    .flags       (flags),
    .stack_err   (stack_err)
  );

  function automatic logic [3:0] tb_mask(input logic [4:0] op);
    int v;
    v = int'(op);
    if (v == 0 || v == 1 || v == 3 || v == 4 || v == 5 || v == 6) return 4'b1111;
    if (v == 8 || v == 9) return 4'b0111;
    if (v == 17 || v == 18 || (v >= 20 && v <= 30)) return 4'b0101;
    return 4'b0000;
  endfunction

  function automatic logic tb_cond(input int cc, input logic [3:0] f);
    logic z, c, s, o;
    z = f[0]; c = f[1]; s = f[2]; o = f[3];
    case (cc)
      0:  return z;
      1:  return !z;
      2:  return c;
      3:  return !c;
      4:  return s;
      5:  return !s;
      6:  return o;
      7:  return !o;
      8:  return !z && (s == o);
      9:  return z || (s != o);
      10: return s == o;
      11: return s != o;
      12: return c && !z;
      13: return !c || z;
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_nib(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Scoreboard: every cond_done must match the oldest queued expectation.
  always @(negedge clock) begin
    if (!reset && cond_done) begin
      if (exp_q.size() != 0) begin
        logic e;
        e = exp_q.pop_front();
        check_bit("cond_taken", cond_taken, e);
        $display("cond result: taken=%b expected=%b", cond_taken, e);
      end else begin
        check_bit("cond_unexpected", exp_q.size() != 0, 1'b1);
      end
    end
  end

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    exp_flags = 4'b0000;
    exp_err = 1'b0;
    mstack.delete();
    exp_q.delete();
  endtask

  task automatic alu(input logic [4:0] op, input logic [3:0] fl);
    logic [3:0] m;
    alu_valid = 1'b1;
    alu_op = op;
    alu_flags = fl;
    #1;
    check_bit("alu_ready", alu_ready, 1'b1);
    step();
    alu_valid = 1'b0;
    m = tb_mask(op);
    exp_flags = (exp_flags & ~m) | (fl & m);
    check_nib("alu_flags", flags, exp_flags);
    $display("alu op=%b in=%b -> flags=%b expected=%b", op, fl, flags, exp_flags);
  endtask

  task automatic query(input int cc);
    cond_valid = 1'b1;
    cond_code = 4'(cc);
    #1;
    check_bit("cond_ready", cond_ready, 1'b1);
    exp_q.push_back(tb_cond(cc, exp_flags));
    step();
    cond_valid = 1'b0;
    check_bit("cond_done", cond_done, 1'b1);
  endtask

  task automatic stack_op(input logic sv, input logic rs);
    save_req = sv;
    restore_req = rs;
    #1;
    check_bit("stk_ready", stk_ready, 1'b1);
    check_bit("alu_ready_accept", alu_ready, 1'b0);
    step();
    save_req = 1'b0;
    restore_req = 1'b0;
    #1;
    check_bit("alu_ready_busy", alu_ready, 1'b0);
    check_bit("stk_ready_busy", stk_ready, 1'b0);
    check_bit("cond_ready_busy", cond_ready, !rs);
    if (rs) begin
      if (mstack.size() == 0) exp_err = 1'b1;
      else exp_flags = mstack.pop_back();
    end else begin
      if (mstack.size() == 4) exp_err = 1'b1;
      else mstack.push_back(exp_flags);
    end
    step();
    check_nib("stack_flags", flags, exp_flags);
    check_bit("stack_err", stack_err, exp_err);
    check_bit("alu_ready_idle", alu_ready, 1'b1);
    $display("stack save=%b restore=%b -> flags=%b err=%b expected flags=%b err=%b",
             sv, rs, flags, stack_err, exp_flags, exp_err);
  endtask

  initial begin
    logic [3:0] pats [9];
    pats = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
             4'b0110, 4'b1100, 4'b1010, 4'b0011};

    do_reset();
    check_nib("rst_flags", flags, 4'b0000);
    check_bit("rst_err", stack_err, 1'b0);
    check_bit("rst_done", cond_done, 1'b0);
    check_bit("rst_taken", cond_taken, 1'b0);
    check_bit("rst_alu_ready", alu_ready, 1'b1);
    check_bit("rst_stk_ready", stk_ready, 1'b0);
    check_bit("rst_cond_ready", cond_ready, 1'b1);

    // Pop on empty straight out of reset
    stack_op(1'b0, 1'b1);
    do_reset();
    check_bit("err_cleared", stack_err, 1'b0);

    // Masked writes
    alu(5'b00000, 4'b1111);
    alu(5'b01000, 4'b0000);
    alu(5'b00000, 4'b0000);
    alu(5'b10100, 4'b1010);
    alu(5'b00010, 4'b1111);
    alu(5'b10100, 4'b1111);
    alu(5'b01001, 4'b1010);
    alu(5'b11111, 4'b0000);
    alu(5'b00110, 4'b0000);

    // Every condition code against a spread of flag patterns
    for (int i = 0; i < 9; i++) begin
      alu(5'b00000, pats[i]);
      for (int cc = 0; cc < 16; cc++) query(cc);
    end

    // Fill, overflow, drain
    for (int v = 1; v <= 4; v++) begin
      alu(5'b00000, 4'(v));
      stack_op(1'b1, 1'b0);
    end
    alu(5'b00000, 4'b0101);
    stack_op(1'b1, 1'b0);
    alu(5'b00000, 4'b0000);
    for (int k = 0; k < 4; k++) stack_op(1'b0, 1'b1);

    // Restore wins over save
    do_reset();
    alu(5'b00000, 4'b0110);
    stack_op(1'b1, 1'b0);
    alu(5'b00000, 4'b1001);
    stack_op(1'b1, 1'b1);

    // ALU update and EQ query in the same cycle
    alu(5'b00000, 4'b0000);
    alu_valid = 1'b1;
    alu_op = 5'b00000;
    alu_flags = 4'b0001;
    cond_valid = 1'b1;
    cond_code = 4'd0;
    #1;
`ifdef FLAG_FWD_EN
    check_bit("fwd_cond_ready", cond_ready, 1'b1);
    exp_q.push_back(tb_cond(0, 4'b0001));
    step();
    alu_valid = 1'b0;
    cond_valid = 1'b0;
    exp_flags = 4'b0001;
    check_bit("fwd_cond_done", cond_done, 1'b1);
`else
    check_bit("stall_cond_ready", cond_ready, 1'b0);
    step();
    alu_valid = 1'b0;
    exp_flags = 4'b0001;
    check_bit("stall_no_done", cond_done, 1'b0);
    #1;
    check_bit("stall_cond_ready2", cond_ready, 1'b1);
    exp_q.push_back(tb_cond(0, exp_flags));
    step();
    cond_valid = 1'b0;
    check_bit("stall_cond_done", cond_done, 1'b1);
`endif
    check_nib("fwd_flags", flags, exp_flags);

    // Reset while in PUSH with a query in flight
    alu(5'b00000, 4'b1011);
    save_req = 1'b1;
    step();
    save_req = 1'b0;
    cond_valid = 1'b1;
    cond_code = 4'd14;
    #1;
    check_bit("push_cond_ready", cond_ready, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    cond_valid = 1'b0;
    exp_flags = 4'b0000;
    exp_err = 1'b0;
    mstack.delete();
    #1;
    check_nib("rstpush_flags", flags, 4'b0000);
    check_bit("rstpush_alu_ready", alu_ready, 1'b1);
    check_bit("rstpush_no_done", cond_done, 1'b0);
    check_bit("rstpush_err", stack_err, 1'b0);
    step();
    // sp must be back at zero: a pop now reports underflow
    stack_op(1'b0, 1'b1);

    step();
    step();
    check_nib("queue_drained", 4'(exp_q.size()), 4'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
